dial_zero_tracker: RTL and testbench

Parametrised dial tracker for the rotating-dial zero-count puzzle. It accepts one rotation per handshake (direction plus binary click count) and keeps the dial position, working in pure binary rather than BCD. It maintains two saturating counters: rotations that end on zero, and every click that lands on zero. It replaces the fixed 100-position BCD pipeline and sits between the input-record streamer and the result display/readout logic.

---
 rtl/dial_zero_tracker.sv | 167 ++++++++++++++++
 tb/tb_dial_zero_tracker.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dial_zero_tracker.sv
// dial_zero_tracker: binary dial-position tracker with zero-landing and
// zero-crossing counters. Accepts one rotation per valid/ready handshake,
// consumes whole revolutions one per cycle, then applies the remainder.
// Optional feature macro: DIAL_CROSS_EN (enables the crossing counter;
// when undefined out_cross_cnt is constant 0).
module dial_zero_tracker #(
    parameter int DIAL_SIZE = 100,
    parameter int START_POS = 50,
    parameter int AMT_W     = 10,
    parameter int CNT_W     = 16,
    localparam int POS_W    = $clog2(DIAL_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_dir,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             cnt_clr,
    output logic             out_done,
    output logic [POS_W-1:0] out_pos,
    output logic [CNT_W-1:0] out_land_cnt,
    output logic [CNT_W-1:0] out_cross_cnt
);

    // Wide enough to hold both the rotation amount and DIAL_SIZE unsigned.
    localparam int XW = ((AMT_W > POS_W) ? AMT_W : POS_W) + 2;
    localparam logic [XW-1:0]    SIZE_X  = XW'(DIAL_SIZE);
    localparam logic [POS_W:0]   SIZE_P  = (POS_W + 1)'(DIAL_SIZE);
    localparam logic [POS_W-1:0] START_P = POS_W'(START_POS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [POS_W-1:0]  pos_q;
    logic [AMT_W-1:0]  rem_q;
    logic              dir_q;
    logic              done_q;
    logic [CNT_W-1:0]  land_q;

    logic              accept;
    logic              rev_step;
    logic              fin_step;
    logic [POS_W-1:0]  new_pos;
    logic              fin_cross;
    logic              land_inc;
    logic              cross_inc;
    logic [XW-1:0]     rem_x;
    logic [POS_W:0]    r_p;
    logic [POS_W:0]    pos_x;
    logic [POS_W:0]    sum;

    assign in_ready = (state_q == IDLE);
    assign accept   = (state_q == IDLE) && in_valid;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave RUN on the edge that applies the sub-revolution remainder.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = RUN;
            RUN:     if (!rev_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Step classification and final-position arithmetic for the remainder.
    always_comb begin
        rem_x     = XW'(rem_q);
        r_p       = (POS_W + 1)'(rem_q);  // only meaningful when rem < DIAL_SIZE
        pos_x     = {1'b0, pos_q};
        sum       = pos_x + r_p;
        rev_step  = (state_q == RUN) && (rem_x >= SIZE_X);
        fin_step  = (state_q == RUN) && (rem_x < SIZE_X);
        new_pos   = pos_q;
        fin_cross = 1'b0;
        if (dir_q) begin
            if (sum >= SIZE_P) begin
                new_pos   = POS_W'(sum - SIZE_P);
                fin_cross = 1'b1;
            end else begin
                new_pos = POS_W'(sum);
            end
        end else if (r_p == '0) begin
            new_pos = pos_q;
        end else if (pos_q == '0) begin
            // Leaving zero to the left does not count as touching it again.
            new_pos = POS_W'(SIZE_P - r_p);
        end else if (r_p >= pos_x) begin
            fin_cross = 1'b1;
            new_pos   = (r_p == pos_x) ? '0 : POS_W'(pos_x + SIZE_P - r_p);
        end else begin
            new_pos = POS_W'(pos_x - r_p);
        end
        land_inc  = fin_step && (new_pos == '0);
        cross_inc = rev_step || (fin_step && fin_cross);
    end

    // Rotation datapath: capture on accept, consume revolutions, commit position.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q  <= START_P;
            rem_q  <= '0;
            dir_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= fin_step;
            if (accept) begin
                rem_q <= in_amt;
                dir_q <= in_dir;
            end else if (rev_step) begin
                rem_q <= AMT_W'(rem_x - SIZE_X);
            end
            if (fin_step) begin
                pos_q <= new_pos;
            end
        end
    end

    // Landing counter: clear beats increment, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            land_q <= '0;
        end else if (land_inc && (land_q != CNT_MAX)) begin
            land_q <= land_q + 1'b1;
        end
    end

`ifdef DIAL_CROSS_EN
    logic [CNT_W-1:0] cross_q;

    // Crossing counter: one per revolution plus a final pass/landing on zero.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cross_q <= '0;
        end else if (cross_inc && (cross_q != CNT_MAX)) begin
            cross_q <= cross_q + 1'b1;
        end
    end

    assign out_cross_cnt = cross_q;
`else
    logic unused_cross_inc;
    assign unused_cross_inc = cross_inc;
    assign out_cross_cnt    = '0;
`endif

    assign out_done     = done_q;
    assign out_pos      = pos_q;
    assign out_land_cnt = land_q;

endmodule

// File: tb/tb_dial_zero_tracker.sv
// Directed bench for dial_zero_tracker: default instance (100 positions,
// start 50) plus a small saturating instance (4 positions, 4-bit counters).
// Expected crossing counts collapse to 0 when DIAL_CROSS_EN is undefined.
module tb_dial_zero_tracker;

`ifdef DIAL_CROSS_EN
    localparam bit CROSS_EN = 1'b1;
`else
    localparam bit CROSS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance
    logic        in_valid, in_dir, cnt_clr;
    logic [9:0]  in_amt;
    logic        in_ready, out_done;
    logic [6:0]  out_pos;
    logic [15:0] out_land_cnt, out_cross_cnt;

    // Small saturating instance
    logic        in_valid2, in_dir2, cnt_clr2;
    logic [9:0]  in_amt2;
    logic        in_ready2, out_done2;
    logic [1:0]  out_pos2;
    logic [3:0]  out_land_cnt2, out_cross_cnt2;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state for the held-valid scenario
    int pos_m, land_m, cross_m;

    dial_zero_tracker dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_dir       (in_dir),
        .in_amt       (in_amt),
        .cnt_clr      (cnt_clr),
        .out_done     (out_done),
        .out_pos      (out_pos),
        .out_land_cnt (out_land_cnt),
        .out_cross_cnt(out_cross_cnt)
    );

    dial_zero_tracker #(
        .DIAL_SIZE(4),
        .START_POS(0),
        .AMT_W    (10),
        .CNT_W    (4)
    ) dut2 (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid2),
        .in_ready     (in_ready2),
        .in_dir       (in_dir2),
        .in_amt       (in_amt2),
        .cnt_clr      (cnt_clr2),
        .out_done     (out_done2),
        .out_pos      (out_pos2),
        .out_land_cnt (out_land_cnt2),
        .out_cross_cnt(out_cross_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int xc(input int v);
        return CROSS_EN ? v : 0;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        cnt_clr   = 1'b0;
        in_valid2 = 1'b0;
        cnt_clr2  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One rotation on the default instance; returns edges from accept to out_done.
    task automatic rot1(input logic dir, input int amt, output int cyc);
        int  guard;
        bit  done;
        guard = 0;
        while (in_ready !== 1'b1 && guard < 2000) begin
            @(posedge clk);
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b1;
        in_dir   = dir;
        in_amt   = 10'(amt);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 2000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            done = (out_done === 1'b1);
        end
        check("rot_done_seen", 32'(done), 32'd1);
    endtask

    // Behavioural dial model on a 100-position dial.
    task automatic model(input logic dir, input int amt);
        int hits, np;
        if (dir) begin
            hits = (pos_m + amt) / 100;
            np   = (pos_m + amt) % 100;
        end else begin
            np = ((pos_m - (amt % 100)) + 100) % 100;
            if (pos_m == 0)       hits = amt / 100;
            else if (amt >= pos_m) hits = (amt - pos_m) / 100 + 1;
            else                  hits = 0;
        end
        cross_m += hits;
        if (np == 0) land_m++;
        pos_m = np;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int    cyc, k, next_acc, consumed, dones, guard;
        bit    done;
        logic  dirs[10];
        int    amts[10];
        int    tab[8];

        in_dir = 1'b0; in_amt = '0; in_dir2 = 1'b0; in_amt2 = '0;
        dirs = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        amts = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};
        tab  = '{30, 250, 7, 120, 45, 99, 310, 3};

        // Reset state
        do_reset();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_done", 32'(out_done), 32'd0);
        check("rst_pos", 32'(out_pos), 32'd50);
        check("rst_land", 32'(out_land_cnt), 32'd0);
        check("rst_cross", 32'(out_cross_cnt), 32'd0);

        // Ten-rotation puzzle sequence, back-to-back
        for (int i = 0; i < 10; i++) rot1(dirs[i], amts[i], cyc);
        check("seq_pos", 32'(out_pos), 32'd32);
        check("seq_land", 32'(out_land_cnt), 32'd3);
        check("seq_cross", 32'(out_cross_cnt), 32'(xc(6)));

        // R1000: ten revolutions plus the final edge
        do_reset();
        rot1(1'b1, 1000, cyc);
        check("r1000_latency", 32'(cyc), 32'd11);
        check("r1000_pos", 32'(out_pos), 32'd50);
        check("r1000_cross", 32'(out_cross_cnt), 32'(xc(10)));
        check("r1000_land", 32'(out_land_cnt), 32'd0);

        // Landing exactly on zero, leaving zero leftwards, zero-click rotation at zero
        do_reset();
        rot1(1'b0, 50, cyc);
        check("l50_pos", 32'(out_pos), 32'd0);
        check("l50_land", 32'(out_land_cnt), 32'd1);
        check("l50_cross", 32'(out_cross_cnt), 32'(xc(1)));
        rot1(1'b0, 5, cyc);
        check("l5_pos", 32'(out_pos), 32'd95);
        check("l5_land", 32'(out_land_cnt), 32'd1);
        check("l5_cross", 32'(out_cross_cnt), 32'(xc(1)));
        rot1(1'b0, 95, cyc);
        check("l95_pos", 32'(out_pos), 32'd0);
        check("l95_land", 32'(out_land_cnt), 32'd2);
        rot1(1'b1, 0, cyc);
        check("r0_latency", 32'(cyc), 32'd1);
        check("r0_pos", 32'(out_pos), 32'd0);
        check("r0_land", 32'(out_land_cnt), 32'd3);
        check("r0_cross", 32'(out_cross_cnt), 32'(xc(2)));

        // Reset three edges into a long rotation abandons it
        in_valid = 1'b1; in_dir = 1'b1; in_amt = 10'd500;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_pos", 32'(out_pos), 32'd50);
        check("midrst_land", 32'(out_land_cnt), 32'd0);
        check("midrst_cross", 32'(out_cross_cnt), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_done === 1'b1) dones++;
            @(posedge clk);
            @(negedge clk);
        end
        check("midrst_no_done", 32'(dones), 32'd0);

        // in_valid held high with in_amt changing every cycle
        pos_m = 50; land_m = 0; cross_m = 0;
        next_acc = 0; consumed = 0; dones = 0;
        for (int c = 0; c < 30; c++) begin
            in_valid = 1'b1;
            in_amt   = 10'(tab[c % 8]);
            in_dir   = ((c % 3) != 1);
            check("hv_ready", 32'(in_ready), 32'(c == next_acc));
            check("hv_done", 32'(out_done), 32'((c == next_acc) && (c != 0)));
            if (out_done === 1'b1) dones++;
            if (c == next_acc) begin
                model(in_dir, tab[c % 8]);
                consumed++;
                next_acc = c + tab[c % 8] / 100 + 2;
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        guard = 0;
        done  = 1'b0;
        while (!done && guard < 20) begin
            if (out_done === 1'b1) dones++;
            if (in_ready === 1'b1) begin
                done = 1'b1;
            end else begin
                @(posedge clk);
                @(negedge clk);
                guard++;
            end
        end
        check("hv_drain", 32'(done), 32'd1);
        check("hv_dones", 32'(dones), 32'(consumed));
        check("hv_pos", 32'(out_pos), 32'(pos_m));
        check("hv_land", 32'(out_land_cnt), 32'(land_m));
        check("hv_cross", 32'(out_cross_cnt), 32'(xc(cross_m)));

        // Small instance: saturation, then clear in the middle of a rotation
        do_reset();
        check("sat_rst_pos", 32'(out_pos2), 32'd0);
        check("sat_rst_ready", 32'(in_ready2), 32'd1);
        in_valid2 = 1'b1; in_dir2 = 1'b1; in_amt2 = 10'd1023;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        k = 0; done = 1'b0;
        while (!done && k < 400) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            done = (out_done2 === 1'b1);
        end
        check("sat_done_seen", 32'(done), 32'd1);
        check("sat_latency", 32'(k), 32'd256);
        check("sat_pos", 32'(out_pos2), 32'd3);
        check("sat_cross", 32'(out_cross_cnt2), 32'(xc(15)));
        check("sat_land", 32'(out_land_cnt2), 32'd0);

        in_valid2 = 1'b1; in_dir2 = 1'b1; in_amt2 = 10'd1023;
        @(posedge clk);
        @(negedge clk);
        in_valid2 = 1'b0;
        k = 0; done = 1'b0;
        while (!done && k < 400) begin
            cnt_clr2 = (k + 1 == 250);
            @(posedge clk);
            k++;
            @(negedge clk);
            cnt_clr2 = 1'b0;
            if (k == 249) check("clr_before", 32'(out_cross_cnt2), 32'(xc(15)));
            if (k == 250) check("clr_edge", 32'(out_cross_cnt2), 32'd0);
            done = (out_done2 === 1'b1);
        end
        check("clr_done_seen", 32'(done), 32'd1);
        check("clr_latency", 32'(k), 32'd256);
        check("clr_pos", 32'(out_pos2), 32'd2);
        check("clr_cross", 32'(out_cross_cnt2), 32'(xc(6)));
        check("clr_land", 32'(out_land_cnt2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
